// File: rtl/serial_frame_pkg.sv
// Shared definitions for the on-chip serial link (receive and transmit ends).
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Widest data word the parity helper accepts; narrower words are zero-extended.
    localparam int MAX_DWIDTH = 64;

    // Expected parity bit for a data word: even parity, inverted for odd parity.
    function automatic logic calc_parity(input logic [MAX_DWIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DWIDTH data bits MSB first, optional parity,
// stop bit. Bits are taken only on strobe edges; results leave as registered pulses.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DWIDTH     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ser_in,
    input  logic              i_ser_en,
    output logic [DWIDTH-1:0] o_par_out,
    output logic              o_valid,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int CW = $clog2(DWIDTH + 1);

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [DWIDTH-1:0] shift;
    logic [DWIDTH-1:0] shift_next;
    logic              perr_flag;
    logic              perr_flag_next;
    logic              load_word;
    logic              frame_bad;

    // Next-state and datapath decode; everything holds unless the strobe is high.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        shift_next     = shift;
        perr_flag_next = perr_flag;
        load_word      = 1'b0;
        frame_bad      = 1'b0;
        if (i_ser_en) begin
            case (state)
                IDLE: begin
                    if (i_ser_in == START_BIT) begin
                        state_next     = DATA;
                        cnt_next       = '0;
                        perr_flag_next = 1'b0;
                    end
                end
                DATA: begin
                    shift_next = DWIDTH'({shift, i_ser_in});
                    cnt_next   = cnt + CW'(1);
                    if (cnt == CW'(DWIDTH - 1)) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    perr_flag_next = (i_ser_in != calc_parity(MAX_DWIDTH'(shift), PARITY_ODD != 0));
                    state_next     = STOP;
                end
                STOP: begin
                    if (i_ser_in == STOP_BIT) begin
                        load_word  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = BREAK;
                    end
                end
                BREAK: begin
                    // Held-low line is ignored until it returns high.
                    if (i_ser_in == IDLE_LEVEL) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, datapath and output registers; pulses self-clear every cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            shift        <= '0;
            perr_flag    <= 1'b0;
            o_par_out    <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            shift       <= shift_next;
            perr_flag   <= perr_flag_next;
            o_valid     <= load_word;
            o_frame_err <= frame_bad;
            if (load_word) begin
                o_par_out    <= shift;
                o_parity_err <= perr_flag;
            end
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx (DWIDTH=8, even parity).
module tb_serial_frame_rx;

    logic       clk;
    logic       rst;
    logic       ser_in;
    logic       ser_en;
    logic [7:0] par_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int unsigned tests;
    int unsigned fails;
    int unsigned cyc;

    typedef struct {
        bit          is_ferr;
        logic [7:0]  data;
        logic        perr;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    logic [7:0] last_word;

    serial_frame_rx #(
        .DWIDTH    (8),
        .PARITY_EN (1),
        .PARITY_ODD(0)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ser_in    (ser_in),
        .i_ser_en    (ser_en),
        .o_par_out   (par_out),
        .o_valid     (valid),
        .o_parity_err(parity_err),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest expected event.
    always @(posedge clk) begin
        #1;
        if (valid || frame_err) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_type", {30'd0, valid, frame_err}, e.is_ferr ? 32'd1 : 32'd2);
                check("par_out", {24'd0, par_out}, {24'd0, e.data});
                if (!e.is_ferr) check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic strobe(input logic b, input int period);
        repeat (period - 1) begin
            @(negedge clk);
            ser_en = 1'b0;
        end
        @(negedge clk);
        ser_in = b;
        ser_en = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ser_en = 1'b0;
            ser_in = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stopbit,
                              input logic exp_perr, input int period);
        exp_t e;
        strobe(1'b0, period);
        for (int i = 7; i >= 0; i--) strobe(data[i], period);
        strobe(pbit, period);
        repeat (period - 1) begin
            @(negedge clk);
            ser_en = 1'b0;
        end
        @(negedge clk);
        e.is_ferr = (stopbit == 1'b0);
        e.data    = e.is_ferr ? last_word : data;
        e.perr    = exp_perr;
        e.cyc     = cyc + 1;
        sb.push_back(e);
        if (!e.is_ferr) last_word = data;
        ser_in = stopbit;
        ser_en = 1'b1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        last_word = 8'h00;
        rst       = 1'b1;
        ser_in    = 1'b1;
        ser_en    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_par_out", {24'd0, par_out}, 32'h0);
        check("reset_flags", {28'd0, valid, parity_err, frame_err, busy}, 32'h0);
        rst = 1'b0;
        idle(2);

        // Good frame, correct even parity.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1);
        idle(2);

        // Wrong parity bit: word delivered with error flag, flag persists.
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1);
        idle(3);
        check("perr_hold", {31'd0, parity_err}, 32'h1);

        // Bad stop bit, then held-low line, then recovery.
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 3; i++) strobe(1'b0, 1);
        @(negedge clk);
        ser_en = 1'b0;
        check("break_busy", {31'd0, busy}, 32'h1);
        check("break_par_out", {24'd0, par_out}, 32'h3C);
        strobe(1'b1, 1);
        @(negedge clk);
        ser_en = 1'b0;
        check("break_exit_idle", {31'd0, busy}, 32'h0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1);
        idle(2);

        // Sparse strobe: one enable every 4th cycle.
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 4);
        idle(2);

        // Reset after four data bits aborts the frame.
        strobe(1'b0, 1);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1);
        @(negedge clk);
        ser_en = 1'b0;
        check("midframe_busy", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_par_out", {24'd0, par_out}, 32'h0);
        check("abort_flags", {28'd0, valid, parity_err, frame_err, busy}, 32'h0);
        last_word = 8'h00;
        idle(3);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1);
        idle(2);

        // Back-to-back frames, no idle strobe between them.
        send_frame(8'h12, 1'b0, 1'b1, 1'b0, 1);
        send_frame(8'h34, 1'b1, 1'b1, 1'b0, 1);
        idle(1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        idle(3);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receives a framed serial bit stream and deserializes it into parallel words.
- Frame on the wire, one bit per enabled sample: start bit (0), DWIDTH data bits MSB first, optional parity bit, stop bit (1). Line idles high.
- This is the receive end of the on-chip serial link. It pairs with the parallel-to-serial transmit path and feeds downstream byte consumers with a one-cycle valid strobe and error flags.

Parameters:
- DWIDTH, 8, number of data bits per frame.
- PARITY_EN, 1, 1 = a parity bit follows the data; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity; 1 = odd parity. Ignored when PARITY_EN = 0.

Ports:
- i_clk  input  1  single system clock; all logic on the rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_ser_in  input  1  serial line, idle high.
- i_ser_en  input  1  bit strobe; i_ser_in is sampled only on edges where this is 1.
- o_par_out  output  DWIDTH  last received word.
- o_valid  output  1  one-cycle pulse: o_par_out was just updated.
- o_parity_err  output  1  parity mismatch on the word flagged by o_valid.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- o_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: one clock, sampled on a rising edge.
  - State goes to IDLE; bit counter, shift register, o_par_out, o_valid, o_parity_err, o_frame_err and o_busy all go to 0.
  - i_rst takes priority over every other event.
  - Reset mid-frame aborts the frame; no o_valid or o_frame_err is generated for it.
- Strobe gating: on edges with i_ser_en = 0, state, counter and shift register hold. o_valid and o_frame_err still self-clear.
- IDLE:
  - Sampled 0 → DATA, bit counter cleared.
  - Sampled 1 → stay in IDLE.
- DATA:
  - Each sample shifts in at the LSB (first bit ends at the MSB) and increments the counter.
  - After DWIDTH samples → PARITY if PARITY_EN = 1, else STOP.
- PARITY:
  - Sample the bit and compare it against the XOR of the data bits (inverted when PARITY_ODD = 1).
  - Hold the mismatch in an internal flag, then → STOP.
- STOP, sampled 1:
  - On the same edge, o_par_out ← shift register, o_valid ← 1, o_parity_err ← mismatch flag.
  - → IDLE.
- STOP, sampled 0:
  - o_frame_err ← 1 for one cycle; o_valid stays 0; o_par_out keeps its previous value.
  - → BREAK.
- BREAK: wait for a sampled 1 → IDLE. Sampled 0s are ignored, so a held-low line never looks like a start bit.
- Latency: o_valid is high in the clock cycle immediately after the edge that sampled the stop bit.
- Flag persistence: o_parity_err holds until the next o_valid or reset. o_valid and o_frame_err are always single-cycle pulses.
- Back-to-back frames: a start bit on the strobe right after a good stop bit is accepted, because IDLE is entered on the stop edge.
- Counter width: $clog2(DWIDTH+1). The counter wraps to 0 on entry to DATA only.

Decomposition:
- Shared package serial_frame_pkg, also used by the transmit side:
  - state encodings IDLE/DATA/PARITY/STOP/BREAK;
  - START_BIT = 0, STOP_BIT = 1, IDLE_LEVEL = 1;
  - the parity function.
- No sub-module: the shifter, counter and FSM are small enough to live inline. RTL target is about 150 lines.

Test Plan:
- DWIDTH = 8, even parity, strobe every cycle. Send 0,1,0,1,0,0,1,0,1 | P = 0 | stop 1 (0xA5) → o_valid pulse 1 cycle after the stop edge, o_par_out = 0xA5, o_parity_err = 0, o_frame_err = 0.
- Send 0x3C with parity bit 1 → o_valid = 1, o_par_out = 0x3C, o_parity_err = 1. The next good frame clears o_parity_err.
- Send 0x81 with stop bit 0 → o_frame_err pulse, no o_valid, o_par_out stays 0x3C. Then hold the line at 0 for 3 strobes → o_busy stays 1, nothing received. Then 1, then frame 0x5A → o_valid, o_par_out = 0x5A.
- i_ser_en high every 4th cycle, frame 0xFF with P = 0 → o_par_out = 0xFF, o_parity_err = 0. State is frozen between strobes.
- Assert i_rst for 1 cycle after 4 data bits → all outputs 0, state IDLE, no pulse. Then frame 0x01 with P = 1 → o_par_out = 0x01, o_parity_err = 0.
- Frames 0x12 and 0x34 back-to-back with no idle strobe between them → two o_valid pulses, values 0x12 then 0x34.
